// File: rtl/int_ctrl_if.sv
// Core-facing interrupt handshake and software register port of int_ctrl.
// master = core/CPU side (drives acks and register writes), slave = controller.
// Signals: irq/nmi requests, irq_ack/nmi_ack pulses, reg_we/reg_addr/reg_wdata/reg_rdata.
interface int_ctrl_if;
    logic       irq;
    logic       nmi;
    logic       irq_ack;
    logic       nmi_ack;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    modport master (
        output irq_ack, nmi_ack, reg_we, reg_addr, reg_wdata,
        input  irq, nmi, reg_rdata
    );

    modport slave (
        input  irq_ack, nmi_ack, reg_we, reg_addr, reg_wdata,
        output irq, nmi, reg_rdata
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt source controller: sync, pending latch, enable mask, lowest-index priority, IRQ/NMI requests.
// Latency: source high -> irq after 4 edges (2 sync + pend + FSM); nmi_in rise -> nmi after 3 edges.
// Backpressure: a request is held until the core acks; no new IRQ is raised until software writes EOI.
// Ports: clk, a_rst (async active-low), src_in[N_SRC], nmi_in, bus (int_ctrl_if.slave: irq/nmi/acks/register port).
module int_ctrl #(
    parameter int          N_SRC    = 8,
    parameter int          SRC_W    = 3,
    parameter logic [7:0]  EDGE_SRC = 8'h00
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic [N_SRC-1:0] src_in,
    input  logic             nmi_in,
    int_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10,
        BAD     = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   src_s1, src_s2, src_s3;
    logic               nmi_s1, nmi_s2, nmi_s3;
    logic [N_SRC-1:0]   pend, pend_d, en, req;
    logic               nmi_pend;
    logic [SRC_W-1:0]   cause_id, win_id;
    logic               cause_valid;
    logic               irq_q;
    logic               take;
    logic               eoi;
    logic               pend_wr;
    logic               en_wr;
    logic [7:0]         rdata;

    // Two-flop synchronisers plus a third stage for rising-edge detection.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            src_s1 <= '0;
            src_s2 <= '0;
            src_s3 <= '0;
            nmi_s1 <= 1'b0;
            nmi_s2 <= 1'b0;
            nmi_s3 <= 1'b0;
        end else begin
            src_s1 <= src_in;
            src_s2 <= src_s1;
            src_s3 <= src_s2;
            nmi_s1 <= nmi_in;
            nmi_s2 <= nmi_s1;
            nmi_s3 <= nmi_s2;
        end
    end

    assign req     = pend & en;
    assign eoi     = bus.reg_we && (bus.reg_addr == 2'd3);
    assign pend_wr = bus.reg_we && (bus.reg_addr == 2'd1);
    assign en_wr   = bus.reg_we && (bus.reg_addr == 2'd0);

    // Lowest index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) win_id = SRC_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) state_d = REQ;
            end
            REQ: begin
                // A vanished request withdraws irq even if an ack lands in the same cycle.
                if (!(|req)) begin
                    state_d = IDLE;
                end else if (bus.irq_ack) begin
                    take    = 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge bits: a new edge beats a simultaneous clear (software write-1 or ack of this bit).
    always_comb begin
        pend_d = pend;
        for (int i = 0; i < N_SRC; i++) begin
            if (EDGE_SRC[i]) begin
                pend_d[i] = (src_s2[i] & ~src_s3[i]) |
                            (pend[i] & ~((pend_wr & bus.reg_wdata[i]) |
                                         (take && (win_id == SRC_W'(i)))));
            end else begin
                pend_d[i] = src_s2[i];
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q     <= IDLE;
            irq_q       <= 1'b0;
            pend        <= '0;
            en          <= '0;
            nmi_pend    <= 1'b0;
            cause_id    <= '0;
            cause_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            irq_q    <= (state_d == REQ);
            pend     <= pend_d;
            nmi_pend <= (nmi_s2 & ~nmi_s3) | (nmi_pend & ~bus.nmi_ack);
            if (en_wr) en <= bus.reg_wdata[N_SRC-1:0];
            if (take) begin
                cause_id    <= win_id;
                cause_valid <= 1'b1;
            end else if ((state_q == SERVICE) && eoi) begin
                cause_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.reg_addr)
            2'd0: rdata[N_SRC-1:0] = en;
            2'd1: rdata[N_SRC-1:0] = pend;
            2'd2: begin
                rdata[7]         = cause_valid;
                rdata[SRC_W-1:0] = cause_id;
            end
            default: rdata = {4'b0000, irq_q, nmi_pend, state_q};
        endcase
    end

    assign bus.reg_rdata = rdata;
    assign bus.irq       = irq_q;
    assign bus.nmi       = nmi_pend;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl (EDGE_SRC=8'hF1: src 0 and 7:4 edge, 3:1 level).
// Expected values are queued when stimulus is applied and popped when the output is observed.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_int_ctrl;
    logic       clk;
    logic       a_rst;
    logic       nmi_in;
    logic [7:0] src_in;

    int_ctrl_if bus();

    int_ctrl #(
        .N_SRC    (8),
        .SRC_W    (3),
        .EDGE_SRC (8'hF1)
    ) dut (
        .clk    (clk),
        .a_rst  (a_rst),
        .src_in (src_in),
        .nmi_in (nmi_in),
        .bus    (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] obs;
    int         vectors     = 0;
    int         miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    function automatic exp_t ex(input string n, input logic [7:0] v);
        exp_t r;
        r.name = n;
        r.val  = v;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.reg_addr = a;
        #1;
        d = bus.reg_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        tick(1);
        bus.reg_we    = 1'b0;
    endtask

    task automatic pulse_irq_ack;
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
    endtask

    task automatic apply_reset;
        a_rst       = 1'b0;
        src_in      = 8'h00;
        nmi_in      = 1'b0;
        bus.irq_ack = 1'b0;
        bus.nmi_ack = 1'b0;
        bus.reg_we  = 1'b0;
        tick(2);
        a_rst = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        sb.push_back(ex("rst_irq", 8'h00));
        sb.push_back(ex("rst_nmi", 8'h00));
        for (int a = 0; a < 4; a++) sb.push_back(ex($sformatf("rst_rd%0d", a), 8'h00));
        obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        obs = {7'b0, bus.nmi};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), obs);
            e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        end
        a_rst = 1'b1;
        tick(1);
    endtask

    // Level src 2 and edge src 5 together; src 2 wins both times.
    task automatic test_level;
        apply_reset();
        wr(2'd0, 8'hFF);
        src_in = 8'h24;
        sb.push_back(ex("lvl_irq_e2", 8'h00));
        sb.push_back(ex("lvl_irq_e3", 8'h01));
        sb.push_back(ex("lvl_pend", 8'h24));
        sb.push_back(ex("lvl_status_req", 8'h09));
        tick(3); obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        tick(1); obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd1, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end

        sb.push_back(ex("lvl_ack_irq", 8'h00));
        sb.push_back(ex("lvl_ack_cause", 8'h82));
        sb.push_back(ex("lvl_ack_status", 8'h02));
        pulse_irq_ack();
        obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd2, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end

        sb.push_back(ex("lvl_eoi_w", 8'h00));
        sb.push_back(ex("lvl_eoi_w1", 8'h09));
        wr(2'd3, 8'h00);
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        tick(1); rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end

        sb.push_back(ex("lvl_ack2_cause", 8'h82));
        pulse_irq_ack();
        rd(2'd2, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
    endtask

    // Entered straight from test_level, still in SERVICE.
    task automatic test_reset_service;
        sb.push_back(ex("rsv_pre_status", 8'h02));
        sb.push_back(ex("rsv_status", 8'h00));
        sb.push_back(ex("rsv_cause", 8'h00));
        sb.push_back(ex("rsv_en", 8'h00));
        sb.push_back(ex("rsv_irq", 8'h00));
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        a_rst = 1'b0;
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd2, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd0, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        tick(1);
    endtask

    task automatic test_edge;
        apply_reset();
        wr(2'd0, 8'h01);
        src_in = 8'h01; tick(1); src_in = 8'h00;
        sb.push_back(ex("edg_pend_held", 8'h01));
        sb.push_back(ex("edg_irq", 8'h01));
        tick(5);
        rd(2'd1, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end

        sb.push_back(ex("edg_ack_pend", 8'h00));
        sb.push_back(ex("edg_ack_cause", 8'h80));
        pulse_irq_ack();
        rd(2'd1, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd2, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end

        // Re-arm, then land a fresh edge on the same edge as the ack.
        wr(2'd3, 8'h00);
        src_in = 8'h01; tick(1); src_in = 8'h00;
        tick(5);
        src_in = 8'h01;
        sb.push_back(ex("edg_setwin_pend", 8'h01));
        sb.push_back(ex("edg_setwin_cause", 8'h80));
        sb.push_back(ex("edg_setwin_status", 8'h02));
        tick(2);
        pulse_irq_ack();
        rd(2'd1, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd2, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
    endtask

    task automatic test_level_drop;
        apply_reset();
        wr(2'd0, 8'h08);
        src_in = 8'h08;
        sb.push_back(ex("drp_irq_up", 8'h01));
        sb.push_back(ex("drp_cause", 8'h83));
        sb.push_back(ex("drp_eoi_cause", 8'h03));
        sb.push_back(ex("drp_rereq_irq", 8'h01));
        tick(4); obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        pulse_irq_ack();
        rd(2'd2, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        wr(2'd3, 8'h00);
        rd(2'd2, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        tick(1); obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end

        src_in = 8'h00;
        sb.push_back(ex("drp_irq_e2", 8'h01));
        sb.push_back(ex("drp_irq_e3", 8'h00));
        sb.push_back(ex("drp_status", 8'h00));
        tick(3); obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        tick(1); obs = {7'b0, bus.irq};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end

        sb.push_back(ex("drp_late_ack_cause", 8'h03));
        sb.push_back(ex("drp_late_ack_status", 8'h00));
        pulse_irq_ack();
        rd(2'd2, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
    endtask

    // NMI activity while the IRQ side sits in SERVICE on level src 1.
    task automatic test_nmi;
        apply_reset();
        wr(2'd0, 8'h02);
        src_in = 8'h02;
        tick(4);
        pulse_irq_ack();
        nmi_in = 1'b1;
        sb.push_back(ex("nmi_e1", 8'h00));
        sb.push_back(ex("nmi_e2", 8'h01));
        sb.push_back(ex("nmi_hold", 8'h01));
        sb.push_back(ex("nmi_status_svc", 8'h06));
        tick(2); obs = {7'b0, bus.nmi};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        tick(1); obs = {7'b0, bus.nmi};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        tick(5); obs = {7'b0, bus.nmi};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end

        nmi_in = 1'b0;
        tick(4);
        nmi_in = 1'b1;
        sb.push_back(ex("nmi_setwin", 8'h01));
        sb.push_back(ex("nmi_cleared", 8'h00));
        sb.push_back(ex("nmi_status_after", 8'h02));
        sb.push_back(ex("nmi_cause_kept", 8'h81));
        tick(2);
        bus.nmi_ack = 1'b1; tick(1); bus.nmi_ack = 1'b0;
        obs = {7'b0, bus.nmi};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        bus.nmi_ack = 1'b1; tick(1); bus.nmi_ack = 1'b0;
        obs = {7'b0, bus.nmi};
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd2, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
    endtask

    task automatic test_pending_write;
        apply_reset();
        src_in = 8'hFF;
        sb.push_back(ex("pw_all", 8'hFF));
        sb.push_back(ex("pw_after_w1c", 8'h0E));
        sb.push_back(ex("pw_level_low", 8'h00));
        sb.push_back(ex("pw_level_0a", 8'h0A));
        sb.push_back(ex("pw_status", 8'h00));
        tick(5); rd(2'd1, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        wr(2'd1, 8'hFF);
        rd(2'd1, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        src_in = 8'h00;
        tick(3); rd(2'd1, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        src_in = 8'h0A;
        tick(3); rd(2'd1, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
        rd(2'd3, obs);
        e = sb.pop_front(); vectors++; if (obs !== e.val) begin miscompares++; $display("FAIL %s: got 0x%02h want 0x%02h", e.name, obs, e.val); end
    endtask

    initial begin
        a_rst         = 1'b0;
        src_in        = 8'h00;
        nmi_in        = 1'b0;
        bus.irq_ack   = 1'b0;
        bus.nmi_ack   = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = 2'd0;
        bus.reg_wdata = 8'h00;
        tick(2);
        test_reset();
        test_level();
        test_reset_service();
        test_edge();
        test_level_drop();
        test_nmi();
        test_pending_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
